ysyx_23060208_ifu_fetch: RTL
============================

Name: ysyx_23060208_ifu_fetch

Overview:
Instruction-fetch stage; the sending end of the IFU->IDU valid/allowin handshake.
- Owns the PC and issues one instruction-memory read at a time over a valid/ready request and response channel.
- Packs {pc, inst} onto ifu_to_idu_bus and holds it until the IDU accepts it.
- Accepts redirects (jal/jalr/branch/ecall/mret targets) from EXU and squashes stale fetches.

Parameters:
DATA_WIDTH, 32, PC and instruction width
RESET_PC, 32'h8000_0000, first fetch address after reset

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  fetch address (always word aligned)
imem_rsp_valid  input  1  read data valid
imem_rsp_data  input  32  instruction word
imem_rsp_ready  output  1  IFU accepts response
redirect_valid  input  1  next-PC override from EXU, single-cycle pulse
redirect_pc  input  32  redirect target; bits[1:0] ignored (treated as 0)
ifu_to_idu_bus  output  64  {pc[63:32], inst[31:0]}
ifu_to_idu_valid  output  1  bus holds a valid instruction
idu_allowin  input  1  IDU can latch this cycle

Behaviour:
Reset (async, rst=1): pc=RESET_PC, state=REQ, kill=0, out_valid=0, out_buf=0. All outputs are 0 except imem_req_addr=RESET_PC. imem_req_valid asserts once rst deasserts.

Handshakes:
- Request fires on imem_req_valid && imem_req_ready.
- Response fires on imem_rsp_valid && imem_rsp_ready.
- IDU transfer fires on ifu_to_idu_valid && idu_allowin.

Outstanding requests: at most one.

Outputs:
- imem_req_addr = pc.
- imem_req_valid = (state==REQ).
- imem_rsp_ready = (state==WAIT).
- ifu_to_idu_valid = out_valid.
- ifu_to_idu_bus = out_buf, registered.

FSM states: REQ, WAIT, HOLD.

REQ:
- Request fire: go to WAIT. If redirect_valid in the same cycle, set kill=1 and pc<=redirect_pc.
- No fire, redirect_valid: pc<=redirect_pc, stay in REQ. The address may change while the request is unaccepted; the imem contract permits this.

WAIT:
- Response fire, kill=1: discard data, kill<=0, go to REQ (pc already holds the target).
- Response fire, kill=0, redirect_valid=1: discard data, pc<=redirect_pc, go to REQ.
- Response fire, kill=0, redirect_valid=0: out_buf<={pc, imem_rsp_data}, out_valid<=1, pc<=pc+4 (wraps mod 2^32), go to HOLD.
- No response, redirect_valid: kill<=1, pc<=redirect_pc, stay in WAIT.

HOLD:
- out_buf stays stable while out_valid=1 and idu_allowin=0.
- Transfer fire: out_valid<=0, go to REQ.
- redirect_valid (with or without transfer): out_valid<=0, pc<=redirect_pc, go to REQ. If the transfer fired in the same cycle, flushing that instruction in IDU is IDU's responsibility.

Throughput and latency:
- Minimum 3 cycles per instruction: REQ, WAIT with 1-cycle memory latency, HOLD with immediate allowin.
- Latency from response fire to ifu_to_idu_valid is 1 cycle.

Further rules:
- A redirect outranks every other event in the same cycle.
- Back-to-back redirects: the last one wins.
- rst asserted mid-operation returns to the reset state immediately. Any in-flight memory response after reset release is not expected; the memory is reset together with this block.

Optional Feature:
Macro IFU_PERF_CNT_EN.
- Defined: two 32-bit wrapping counters, both cleared by rst.
  - fetch_cnt increments on each IDU transfer fire.
  - stall_cnt increments each cycle out_valid=1 && idu_allowin=0.
  - DPI-C export task get_ifu_perf(output [31:0] fetch, output [31:0] stall).
- Undefined: counters and task are absent; ports and timing are identical either way.

Decomposition:
Shared header/package holds:
- IFU_TO_IDU_BUS (64)
- RESET_PC
- FSM state encodings REQ=2'b00, WAIT=2'b01, HOLD=2'b10

One natural sub-module: ysyx_23060208_ifu_outbuf. It is the {pc,inst} register plus out_valid with load, accept and flush inputs; the FSM and PC logic stay in the top module.

Test Plan:
1. Reset release, memory ready=1, 1-cycle latency, inst 32'h00000013 -> request addr 8000_0000; bus {8000_0000, 0000_0013} valid 1 cycle after response; next request addr 8000_0004.
2. idu_allowin=0 for 5 cycles while valid -> bus stable, no new imem request; allowin=1 -> valid drops next cycle, request at pc+4.
3. redirect_valid with redirect_pc=8000_0100 while in WAIT, response arrives 3 cycles later with 32'hDEADBEEF -> data never appears on the bus; next request addr 8000_0100.
4. redirect_pc=8000_0203 in HOLD -> valid drops next cycle; next request addr 8000_0200.
5. Response and redirect in the same cycle -> response discarded, next request at the redirect target; pc=FFFF_FFFC fetch -> next addr 0000_0000.
6. rst pulsed in WAIT -> ifu_to_idu_valid=0 immediately, imem_req_addr=8000_0000; with IFU_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/ysyx_23060208_ifu_fetch_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060208_ifu_fetch_pkg
// Shared definitions for the instruction-fetch unit:
//   IFU_TO_IDU_BUS : width of the {pc, inst} bus handed to the IDU
//   RESET_PC       : first fetch address after reset
//   fetch_state_e  : fetch FSM encodings (REQ / WAIT / HOLD)
//   align_pc()     : forces a redirect target onto a word boundary
// ---------------------------------------------------------------------------
package ysyx_23060208_ifu_fetch_pkg;

    localparam int          IFU_TO_IDU_BUS = 64;
    localparam logic [31:0] RESET_PC       = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'b00,  // request presented to imem
        ST_WAIT = 2'b01,  // request accepted, waiting for the response
        ST_HOLD = 2'b10   // instruction parked on the IDU bus
    } fetch_state_e;

    // Redirect targets may carry junk in bits [1:0]; fetches are always
    // word aligned, so those bits are simply dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_23060208_ifu_outbuf.sv
// ---------------------------------------------------------------------------
// ysyx_23060208_ifu_outbuf
// Output register of the IFU: holds {pc, inst} plus its valid flag until the
// IDU accepts it or a redirect flushes it.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   i_load          : capture i_load_data and raise o_valid
//   i_load_data     : {pc, inst} to capture
//   i_accept        : IDU took the instruction this cycle
//   i_flush         : redirect, drop the instruction
//   o_valid, o_data : registered valid flag and bus contents
// ---------------------------------------------------------------------------
module ysyx_23060208_ifu_outbuf #(
    parameter int BUS_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic [BUS_WIDTH-1:0] i_load_data,
    input  logic                 i_accept,
    input  logic                 i_flush,
    output logic                 o_valid,
    output logic [BUS_WIDTH-1:0] o_data
);

    logic                 r_valid;
    logic [BUS_WIDTH-1:0] r_data;

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_load_data;
        end else if (i_accept || i_flush) begin
            // Data is left in place; only the valid flag matters downstream.
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/ysyx_23060208_ifu_fetch.sv
// ---------------------------------------------------------------------------
// ysyx_23060208_ifu_fetch
// Instruction-fetch stage: owns the PC, issues one imem read at a time over
// a valid/ready request/response pair, and hands {pc, inst} to the IDU over
// a valid/allowin handshake. EXU redirects override the PC and squash any
// fetch already in flight.
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   imem_req_valid/ready/addr        : fetch request channel
//   imem_rsp_valid/data/ready        : fetch response channel
//   redirect_valid, redirect_pc      : next-PC override pulse from EXU
//   ifu_to_idu_bus/valid, idu_allowin: handshake towards the IDU
// Optional build macro IFU_PERF_CNT_EN: adds fetch/stall counters readable
// through task get_ifu_perf. Ports and timing are unchanged.
// ---------------------------------------------------------------------------
module ysyx_23060208_ifu_fetch
    import ysyx_23060208_ifu_fetch_pkg::*;
#(
    parameter int                     DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]  RESET_PC   = ysyx_23060208_ifu_fetch_pkg::RESET_PC
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      imem_req_valid,
    input  logic                      imem_req_ready,
    output logic [DATA_WIDTH-1:0]     imem_req_addr,
    input  logic                      imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]     imem_rsp_data,
    output logic                      imem_rsp_ready,
    input  logic                      redirect_valid,
    input  logic [DATA_WIDTH-1:0]     redirect_pc,
    output logic [2*DATA_WIDTH-1:0]   ifu_to_idu_bus,
    output logic                      ifu_to_idu_valid,
    input  logic                      idu_allowin
);

    fetch_state_e            r_state, w_state_next;
    logic [DATA_WIDTH-1:0]   r_pc, w_pc_next;
    logic                    r_kill, w_kill_next;
    logic                    w_load, w_flush;
    logic                    w_req_fire, w_rsp_fire, w_xfer_fire;
    logic                    w_out_valid;
    logic [DATA_WIDTH-1:0]   w_redirect_pc;

    assign w_redirect_pc = {redirect_pc[DATA_WIDTH-1:2], 2'b00};

    // Request valid is held low while rst is asserted so every output except
    // the address reads 0 during reset.
    assign imem_req_valid   = (r_state == ST_REQ) && !rst;
    assign imem_req_addr    = r_pc;
    assign imem_rsp_ready   = (r_state == ST_WAIT);
    assign ifu_to_idu_valid = w_out_valid;

    assign w_req_fire  = imem_req_valid && imem_req_ready;
    assign w_rsp_fire  = imem_rsp_valid && imem_rsp_ready;
    assign w_xfer_fire = w_out_valid && idu_allowin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_REQ;
            r_pc    <= RESET_PC;
            r_kill  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_kill  <= w_kill_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_kill_next  = r_kill;
        w_load       = 1'b0;
        w_flush      = 1'b0;
        unique case (r_state)
            ST_REQ: begin
                if (w_req_fire) begin
                    w_state_next = ST_WAIT;
                    // Request already left with the old address: its
                    // response must be dropped when it comes back.
                    if (redirect_valid) begin
                        w_kill_next = 1'b1;
                        w_pc_next   = w_redirect_pc;
                    end
                end else if (redirect_valid) begin
                    w_pc_next = w_redirect_pc;
                end
            end
            ST_WAIT: begin
                if (w_rsp_fire) begin
                    w_state_next = ST_REQ;
                    w_kill_next  = 1'b0;
                    if (redirect_valid) begin
                        w_pc_next = w_redirect_pc;
                    end else if (!r_kill) begin
                        w_load       = 1'b1;
                        w_pc_next    = r_pc + DATA_WIDTH'(4);
                        w_state_next = ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    w_kill_next = 1'b1;
                    w_pc_next   = w_redirect_pc;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    w_flush      = 1'b1;
                    w_pc_next    = w_redirect_pc;
                    w_state_next = ST_REQ;
                end else if (w_xfer_fire) begin
                    w_state_next = ST_REQ;
                end
            end
            default: w_state_next = ST_REQ;
        endcase
    end

    ysyx_23060208_ifu_outbuf #(
        .BUS_WIDTH (2*DATA_WIDTH)
    ) u_outbuf (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_load_data ({r_pc, imem_rsp_data}),
        .i_accept    (w_xfer_fire),
        .i_flush     (w_flush),
        .o_valid     (w_out_valid),
        .o_data      (ifu_to_idu_bus)
    );

`ifdef IFU_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_xfer_fire)
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (w_out_valid && !idu_allowin)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    task get_ifu_perf(output logic [31:0] fetch, output logic [31:0] stall);
        fetch = r_fetch_cnt;
        stall = r_stall_cnt;
    endtask
`endif

endmodule
